// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   XLEN_DEF   : default data width in bits
//   NREGS_DEF  : default register count (power of two)
//   REG_AW     : address width for the default register count
//   reg_addr_t : register-address type for the default configuration
package regfile_mp_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_AW    = $clog2(NREGS_DEF);

  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Ports:
//   clk_i, rst_n_i : clock (rising edge) and async active-low reset
//   wr_we_i/wr_addr_i : writebacks; a written register becomes not-busy
//   rsv_we_i/rsv_addr_i : reservation at issue; marks the register busy
//   flush_i        : clears every busy bit on the next edge
//   busy_o         : registered scoreboard state
//   busy_next_o    : state that will be loaded on the next edge
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NWR-1:0]          wr_we_i,
  input  logic [NWR-1:0][AW-1:0]  wr_addr_i,
  input  logic                    rsv_we_i,
  input  logic [AW-1:0]           rsv_addr_i,
  input  logic                    flush_i,
  output logic [NREGS-1:0]        busy_o,
  output logic [NREGS-1:0]        busy_next_o
);

  // Order matters: writebacks clear first, then a reservation sets, so a
  // same-cycle reserve supersedes the retiring writeback. Flush overrides all.
  always_comb begin
    busy_next_o = busy_o;
    for (int k = 0; k < NWR; k++) begin
      if (wr_we_i[k] && (wr_addr_i[k] != '0)) begin
        busy_next_o[wr_addr_i[k]] = 1'b0;
      end
    end
    if (rsv_we_i && (rsv_addr_i != '0)) begin
      busy_next_o[rsv_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_next_o = '0;
    end
    busy_next_o[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_o <= '0;
    end else begin
      busy_o <= busy_next_o;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass and busy-bit scoreboard.
// Ports:
//   clk_i, rst_n_i        : clock (rising edge) and async active-low reset
//   rd_addr_i/rd_data_o   : NRD read ports (combinational or registered)
//   rd_busy_o             : per read port, selected register has a pending writeback
//   wr_we_i/wr_addr_i/wr_data_i : NWR write ports, higher index wins on conflict
//   rsv_we_i/rsv_addr_i   : destination reservation at issue
//   flush_i               : clear all busy bits
//   busy_o                : registered scoreboard vector
// Register 0 is hard-wired to zero and never busy.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int RD_LAT = 0,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]           rd_busy_o,
  input  logic [NWR-1:0]           wr_we_i,
  input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
  input  logic                     rsv_we_i,
  input  logic [AW-1:0]            rsv_addr_i,
  input  logic                     flush_i,
  output logic [NREGS-1:0]         busy_o
);

  logic [XLEN-1:0]           mem [NREGS];
  logic [NREGS-1:0]          busy_next;
  logic [NRD-1:0][XLEN-1:0]  fwd_data;
  logic [NRD-1:0]            wr_hit;
  logic [NRD-1:0]            src_busy;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wr_we_i     (wr_we_i),
    .wr_addr_i   (wr_addr_i),
    .rsv_we_i    (rsv_we_i),
    .rsv_addr_i  (rsv_addr_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .busy_next_o (busy_next)
  );

  // Later ports are applied last, so the higher-indexed port wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_we_i[k] && (wr_addr_i[k] != '0)) begin
          mem[wr_addr_i[k]] <= wr_data_i[k];
        end
      end
    end
  end

  // fwd_data is the value the addressed register holds after this edge:
  // the winning write data if written this cycle, otherwise the array.
  // That is the zero-latency bypass value and also what the registered
  // read port must capture.
  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      wr_hit[j]   = 1'b0;
      fwd_data[j] = mem[rd_addr_i[j]];
      for (int k = 0; k < NWR; k++) begin
        if (wr_we_i[k] && (wr_addr_i[k] == rd_addr_i[j])) begin
          wr_hit[j]   = 1'b1;
          fwd_data[j] = wr_data_i[k];
        end
      end
      if (rd_addr_i[j] == '0) begin
        wr_hit[j]   = 1'b0;
        fwd_data[j] = '0;
      end
      // Combinational mode reports the current state masked by an
      // in-flight writeback; registered mode captures the post-edge state.
      if (RD_LAT == 0) begin
        src_busy[j] = busy_o[rd_addr_i[j]] & ~wr_hit[j];
      end else begin
        src_busy[j] = busy_next[rd_addr_i[j]];
      end
    end
  end

  if (RD_LAT == 0) begin : g_rd_comb
    assign rd_data_o = fwd_data;
    assign rd_busy_o = src_busy;
  end else begin : g_rd_reg
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rd_data_o <= '0;
        rd_busy_o <= '0;
      end else begin
        rd_data_o <= fwd_data;
        rd_busy_o <= src_busy;
      end
    end
  end

endmodule
